if_of_advance_ctrl: RTL and testbench
=====================================

Name: if_of_advance_ctrl

Overview:
- Fetch and operand-fetch advance controller for the 5-stage SimpleRISC pipeline.
- Holds the PC, the IF/OF instruction latch and the OF/EX instruction latch.
- Consumes the combinational data-interlock flag and the EX-stage branch outcome. Stalls, injects bubbles and redirects accordingly.
- Its of_instruction and ex_ir outputs are the OF and EX instruction words fed back into the interlock checker.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h6800_0000, SimpleRISC nop (opcode 5'b01101, rest zero), used for every bubble.
- HALT_OPCODE, 5'b11111, opcode that freezes fetch once it reaches EX.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  instruction memory address; equals pc.
- imem_rdata  input  32  instruction word at imem_addr, combinational, same cycle.
- is_data_interlock  input  1  combinational RAW hazard flag computed from of_instruction vs ex_ir/MA/RW.
- is_branch_taken  input  1  EX-stage instruction is a taken branch this cycle.
- branch_pc  input  32  redirect target; valid when is_branch_taken=1.
- pc  output  32  current fetch PC.
- of_pc  output  32  PC of the instruction in OF.
- of_instruction  output  32  IF/OF latch contents.
- ex_pc  output  32  PC of the instruction in EX.
- ex_ir  output  32  OF/EX latch contents.
- ex_bubble  output  1  1 when ex_ir is an injected bubble.
- halted  output  1  fetch frozen.
- stall_count  output  STALL_CNT_W  number of interlock stall cycles since reset, saturating.

Behaviour:
- Reset (async, rst_n=0), all outputs forced immediately:
  - pc=RESET_PC; of_pc=0; ex_pc=0.
  - of_instruction=NOP_WORD; ex_ir=NOP_WORD; ex_bubble=1.
  - halted=0; stall_count=0; state=BOOT.
- Deassertion takes effect at the next rising edge.
- States:
  - BOOT: one cycle. PC holds, latches hold nops, then go to RUN. Gives the memory one cycle after reset.
  - RUN: normal operation.
  - HALTED: pc, of_instruction and of_pc frozen. ex_ir=NOP_WORD, ex_bubble=1 every cycle. halted=1. Only reset exits HALTED.
- RUN per-cycle priority, evaluated on the edge, first match wins:
  1. is_branch_taken=1:
     - pc<=branch_pc.
     - of_instruction<=NOP_WORD; ex_ir<=NOP_WORD; ex_bubble<=1.
     - The wrong-path OF and IF instructions are killed.
     - is_data_interlock is ignored; no stall is counted.
  2. is_data_interlock=1:
     - pc and IF/OF latch hold.
     - ex_ir<=NOP_WORD; ex_bubble<=1.
     - stall_count<=stall_count+1, saturating at all-ones.
  3. Otherwise:
     - pc<=pc+4, wrapping modulo 2^32.
     - of_instruction<=imem_rdata; of_pc<=pc.
     - ex_ir<=of_instruction; ex_pc<=of_pc; ex_bubble<=0.
- Halt:
  - When ex_ir[31:27]==HALT_OPCODE and ex_bubble=0 at a rising edge in RUN with no branch taken, the next state is HALTED.
  - The same edge applies rule 2 or 3, except that pc does not advance.
  - A branch-taken on the same edge wins; no halt is taken.
- Latency:
  - An instruction fetched at cycle N appears on of_instruction at N+1.
  - It appears on ex_ir at N+2, plus one cycle per interlock stall.
  - Branch penalty is 2 bubbles.
- imem_addr=pc combinationally. No other combinational input-to-output paths, so the interlock checker sees only registered words and no loop is formed.
- In BOOT and HALTED, is_branch_taken and is_data_interlock are ignored.

Decomposition:
- Shared package holds:
  - NOP_WORD and the SimpleRISC opcode constants (nop 5'b01101, halt, branch set), shared with the interlock checker.
  - The state enum {BOOT, RUN, HALTED}.
- One natural sub-module, sat_counter (width-parameterised increment-enable saturating counter), used for stall_count.

Test Plan:
- Reset mid-run:
  - Run 5 cycles, assert rst_n=0 between edges.
  - pc=0 and ex_ir=32'h6800_0000 immediately, without waiting for an edge.
  - After release: BOOT 1 cycle, then first fetch at pc=0.
- Straight-line fetch:
  - imem returns A@0, B@4, C@8, no hazards.
  - ex_ir sequence after BOOT: nop, A, B, C.
  - ex_pc sequence: 0, 4, 8.
- Interlock:
  - Hold is_data_interlock=1 for 2 cycles while of_instruction=B.
  - pc stays 8; of_instruction stays B.
  - ex_ir=nop twice with ex_bubble=1, then B; stall_count=2.
- Branch over interlock:
  - Drive is_branch_taken=1, branch_pc=32'h100 and is_data_interlock=1 on the same edge.
  - pc=32'h100; of_instruction=nop; ex_ir=nop; stall_count unchanged.
- Halt:
  - HALT_OPCODE word reaches EX.
  - Next cycle halted=1; pc frozen; ex_ir stays nop.
  - Asserting is_branch_taken afterwards has no effect.
- Saturation and wrap:
  - Preload 2^16+3 interlock cycles: stall_count=16'hFFFF.
  - Start with RESET_PC=32'hFFFF_FFFC: second fetch at pc=0.

Source files
------------

// File: rtl/if_of_advance_ctrl_pkg.sv
// rtl/if_of_advance_ctrl_pkg.sv - SimpleRISC opcode constants and advance-controller state type
package if_of_advance_ctrl_pkg;

  // Canonical SimpleRISC nop: opcode 5'b01101, all other fields zero.
  localparam logic [31:0] SR_NOP_WORD = 32'h6800_0000;

  // Opcodes shared with the interlock checker.
  localparam logic [4:0] OPC_NOP  = 5'b01101;
  localparam logic [4:0] OPC_HALT = 5'b11111;
  localparam logic [4:0] OPC_BEQ  = 5'b10000;
  localparam logic [4:0] OPC_BGT  = 5'b10001;
  localparam logic [4:0] OPC_B    = 5'b10010;
  localparam logic [4:0] OPC_CALL = 5'b10011;
  localparam logic [4:0] OPC_RET  = 5'b10100;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } adv_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[31:27];
  endfunction

  function automatic logic is_branch_opcode(input logic [4:0] opc);
    return (opc == OPC_BEQ) || (opc == OPC_BGT) || (opc == OPC_B) ||
           (opc == OPC_CALL) || (opc == OPC_RET);
  endfunction

endpackage

// File: rtl/if_of_advance_ctrl_sat_counter.sv
// rtl/if_of_advance_ctrl_sat_counter.sv - increment-enable counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count enabled cycles; once all-ones the value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_of_advance_ctrl.sv
// rtl/if_of_advance_ctrl.sv - IF/OF advance controller: PC, IF/OF and OF/EX latches, stall/bubble/redirect
module if_of_advance_ctrl
  import if_of_advance_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = SR_NOP_WORD,
  parameter logic [4:0]  HALT_OPCODE = OPC_HALT,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   is_data_interlock,
  input  logic                   is_branch_taken,
  input  logic [31:0]            branch_pc,
  output logic [31:0]            pc,
  output logic [31:0]            of_pc,
  output logic [31:0]            of_instruction,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_ir,
  output logic                   ex_bubble,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  adv_state_e  state, next_state;
  logic [31:0] pc_q;
  logic [31:0] of_pc_q;
  logic [31:0] of_ir_q;
  logic [31:0] ex_pc_q;
  logic [31:0] ex_ir_q;
  logic        ex_bub_q;

  logic        halt_hit;
  logic        do_redirect;
  logic        do_stall;
  logic        do_advance;
  logic        do_flush_ex;
  logic        pc_inc;

  // A real (non-bubble) halt sitting in EX freezes fetch.
  assign halt_hit = (opcode_of(ex_ir_q) == HALT_OPCODE) && !ex_bub_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-cycle action: branch beats interlock beats advance.
  always_comb begin
    next_state  = state;
    do_redirect = 1'b0;
    do_stall    = 1'b0;
    do_advance  = 1'b0;
    do_flush_ex = 1'b0;
    pc_inc      = 1'b0;
    case (state)
      ST_BOOT: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (is_branch_taken) begin
          do_redirect = 1'b1;
        end else begin
          if (is_data_interlock) begin
            do_stall = 1'b1;
          end else begin
            do_advance = 1'b1;
            pc_inc     = !halt_hit;
          end
          if (halt_hit) begin
            next_state = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        do_flush_ex = 1'b1;
      end
      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

  // PC and pipeline latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      of_pc_q  <= '0;
      of_ir_q  <= NOP_WORD;
      ex_pc_q  <= '0;
      ex_ir_q  <= NOP_WORD;
      ex_bub_q <= 1'b1;
    end else begin
      if (do_redirect) begin
        pc_q <= branch_pc;
      end else if (pc_inc) begin
        pc_q <= pc_q + 32'd4;
      end

      if (do_redirect) begin
        of_ir_q  <= NOP_WORD;
        ex_ir_q  <= NOP_WORD;
        ex_bub_q <= 1'b1;
      end else if (do_stall || do_flush_ex) begin
        ex_ir_q  <= NOP_WORD;
        ex_bub_q <= 1'b1;
      end else if (do_advance) begin
        of_ir_q  <= imem_rdata;
        of_pc_q  <= pc_q;
        ex_ir_q  <= of_ir_q;
        ex_pc_q  <= of_pc_q;
        ex_bub_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_stall),
    .count (stall_count)
  );

  // The EX slot reads as a bubble from the first halted cycle onward,
  // including the word that followed the halt into EX on the halting edge.
  assign halted         = (state == ST_HALTED);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign of_pc          = of_pc_q;
  assign of_instruction = of_ir_q;
  assign ex_pc          = ex_pc_q;
  assign ex_ir          = halted ? NOP_WORD : ex_ir_q;
  assign ex_bubble      = ex_bub_q | halted;

endmodule

// File: tb/tb_if_of_advance_ctrl.sv
// tb/tb_if_of_advance_ctrl.sv - self-checking bench for if_of_advance_ctrl
module tb_if_of_advance_ctrl;

  localparam logic [31:0] NOP   = 32'h6800_0000;
  localparam logic [31:0] W_A   = 32'h0111_1111;
  localparam logic [31:0] W_B   = 32'h0A22_2222;
  localparam logic [31:0] W_C   = 32'h1333_3333;
  localparam logic [31:0] W_D   = 32'h2044_4444;
  localparam logic [31:0] W_H   = 32'hF800_0000;
  localparam logic [31:0] W_E   = 32'h0955_5555;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        is_data_interlock, is_branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] pc, of_pc, of_instruction, ex_pc, ex_ir;
  logic        ex_bubble, halted;
  logic [15:0] stall_count;

  logic [31:0] w_imem_addr, w_rdata, w_pc, w_of_pc, w_of_instruction, w_ex_pc, w_ex_ir;
  logic        w_ex_bubble, w_halted;
  logic [15:0] w_stall_count;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  if_of_advance_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .is_data_interlock(is_data_interlock), .is_branch_taken(is_branch_taken),
    .branch_pc(branch_pc), .pc(pc), .of_pc(of_pc), .of_instruction(of_instruction),
    .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_bubble(ex_bubble), .halted(halted),
    .stall_count(stall_count)
  );

  if_of_advance_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_rdata(w_rdata),
    .is_data_interlock(is_data_interlock), .is_branch_taken(is_branch_taken),
    .branch_pc(branch_pc), .pc(w_pc), .of_pc(w_of_pc), .of_instruction(w_of_instruction),
    .ex_pc(w_ex_pc), .ex_ir(w_ex_ir), .ex_bubble(w_ex_bubble), .halted(w_halted),
    .stall_count(w_stall_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return W_A;
      32'h0000_0004: return W_B;
      32'h0000_0008: return W_C;
      32'h0000_0100: return W_D;
      32'h0000_0104: return W_H;
      32'h0000_0108: return W_E;
      default:       return 32'h1000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  // Instruction memory: combinational read at the DUT's fetch address.
  always_comb imem_rdata = mem_word(imem_addr);
  assign w_rdata = NOP;

  // Behavioural model: fetch address plus OF and EX slots.
  typedef struct packed {
    logic        live;
    logic [31:0] pc;
    logic [31:0] word;
  } slot_t;

  int          m_mode;
  logic [31:0] m_fpc;
  slot_t       m_of, m_ex;
  int          m_stalls;

  function automatic void model_reset();
    m_mode     = 0;
    m_fpc      = 32'h0;
    m_of.live  = 1'b0; m_of.pc = 32'h0; m_of.word = NOP;
    m_ex.live  = 1'b0; m_ex.pc = 32'h0; m_ex.word = NOP;
    m_stalls   = 0;
  endfunction

  function automatic void model_step(input logic br, input logic il, input logic [31:0] tgt);
    logic halt_hit;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      halt_hit = m_ex.live && (m_ex.word[31:27] == 5'b11111);
      if (br) begin
        m_fpc      = tgt;
        m_of.word  = NOP;
        m_ex.live  = 1'b0;
        m_ex.word  = NOP;
      end else begin
        if (il) begin
          m_ex.live = 1'b0;
          m_ex.word = NOP;
          if (m_stalls < 65535) m_stalls = m_stalls + 1;
        end else begin
          m_ex      = m_of;
          m_ex.live = 1'b1;
          m_of.live = 1'b1;
          m_of.pc   = m_fpc;
          m_of.word = mem_word(m_fpc);
          if (!halt_hit) m_fpc = m_fpc + 32'd4;
        end
        if (halt_hit) m_mode = 2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every clock edge out of reset.
  always @(posedge clk) begin
    if (rst_n) model_step(is_branch_taken, is_data_interlock, branch_pc);
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pc",          pc,             m_fpc);
      chk("m_imem_addr",   imem_addr,      m_fpc);
      chk("m_of_pc",       of_pc,          m_of.pc);
      chk("m_of_instr",    of_instruction, m_of.word);
      chk("m_ex_pc",       ex_pc,          m_ex.pc);
      chk("m_ex_ir",       ex_ir,          (m_mode == 2) ? NOP : m_ex.word);
      chk("m_ex_bubble",   {31'h0, ex_bubble}, {31'h0, (m_mode == 2) || !m_ex.live});
      chk("m_halted",      {31'h0, halted},    {31'h0, m_mode == 2});
      chk("m_stall_count", {16'h0, stall_count}, m_stalls);
    end
  end

  task automatic step(input logic b, input logic i, input logic [31:0] t);
    is_branch_taken   = b;
    is_data_interlock = i;
    branch_pc         = t;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc_async",     pc,    32'h0);
    chk("rst_ex_ir_async",  ex_ir, NOP);
    chk("rst_bubble_async", {31'h0, ex_bubble}, 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    is_data_interlock = 1'b0;
    is_branch_taken   = 1'b0;
    branch_pc         = 32'h0;
    model_reset();
    #12;
    chk("rst_pc",      pc,    32'h0);
    chk("rst_ex_ir",   ex_ir, NOP);
    chk("rst_of_ir",   of_instruction, NOP);
    chk("rst_stall",   {16'h0, stall_count}, 32'h0);
    chk("rst_halted",  {31'h0, halted}, 32'h0);
    chk("rst_w_pc",    w_pc,  32'hFFFF_FFFC);
    rst_n    = 1'b1;
    check_en = 1'b1;

    step(1'b0, 1'b0, 32'h0);
    chk("boot_pc_hold", pc,   32'h0);
    chk("boot_w_pc",    w_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_w_pc",    w_pc, 32'h0);
    chk("first_pc",     pc,   32'h4);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);

    do_reset();
    step(1'b0, 1'b0, 32'h0);
    chk("boot2_pc", pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("f1_pc", pc, 32'h4);
    chk("f1_of", of_instruction, W_A);
    chk("f1_ex", ex_ir, NOP);
    step(1'b0, 1'b0, 32'h0);
    chk("f2_ex", ex_ir, W_A);
    chk("f2_expc", ex_pc, 32'h0);
    chk("f2_of", of_instruction, W_B);

    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    chk("il_pc", pc, 32'h8);
    chk("il_of", of_instruction, W_B);
    chk("il_ex", ex_ir, NOP);
    chk("il_bub", {31'h0, ex_bubble}, 32'h1);
    chk("il_cnt", {16'h0, stall_count}, 32'd2);
    step(1'b0, 1'b0, 32'h0);
    chk("il_rel_ex", ex_ir, W_B);
    chk("il_rel_expc", ex_pc, 32'h4);
    chk("il_rel_pc", pc, 32'hC);
    step(1'b0, 1'b0, 32'h0);
    chk("f_c_ex", ex_ir, W_C);
    chk("f_c_expc", ex_pc, 32'h8);

    step(1'b1, 1'b1, 32'h100);
    chk("br_pc", pc, 32'h100);
    chk("br_of", of_instruction, NOP);
    chk("br_ex", ex_ir, NOP);
    chk("br_cnt", {16'h0, stall_count}, 32'd2);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("pre_halt_ex", ex_ir, W_D);
    step(1'b0, 1'b0, 32'h0);
    chk("halt_in_ex", ex_ir, W_H);
    chk("halt_pc", pc, 32'h10C);
    step(1'b0, 1'b0, 32'h0);
    chk("halted_flag", {31'h0, halted}, 32'h1);
    chk("halted_pc", pc, 32'h10C);
    chk("halted_ex", ex_ir, NOP);
    step(1'b1, 1'b0, 32'h200);
    chk("halted_br_pc", pc, 32'h10C);
    chk("halted_br_ex", ex_ir, NOP);
    step(1'b0, 1'b0, 32'h0);

    do_reset();
    step(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 65539; k++) step(1'b0, 1'b1, 32'h0);
    chk("sat_cnt", {16'h0, stall_count}, 32'h0000_FFFF);
    chk("sat_pc",  pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
